bist_checker: RTL and testbench

- Consumer end of the deterministic pattern-generator interface: drives `pg_en`, takes each generated op (`addr`, `we`, `re`, `data`, `check`, `wmask`) and issues it to the SRAM macro port.
- Delays the expected read data to match SRAM read latency and compares it against `sram_dout`.
- Accumulates pass/fail results; sits between any march patgen and the SRAM under test in the BIST wrapper.

---
 rtl/bist_checker_pkg.sv | 13 +
 rtl/bist_exp_pipe.sv | 45 ++++
 rtl/bist_checker.sv | 148 ++++++++++++++
 tb/tb_bist_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_checker_pkg.sv
// Shared types and constants for the BIST result checker.
package bist_checker_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_checker_state_t;

    // DRAIN covers the issue register plus the SRAM read latency.
    localparam int DRAIN_EXTRA = 1;

    function automatic int drain_len(input int read_latency);
        return read_latency + DRAIN_EXTRA;
    endfunction

endpackage

// File: rtl/bist_exp_pipe.sv
// Expected-read delay line: carries {valid, check, addr} to the compare point.
module bist_exp_pipe
    import bist_checker_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  push_vld,
    input  logic [DATA_WIDTH-1:0] push_check,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    output logic                  tail_vld,
    output logic [DATA_WIDTH-1:0] tail_check,
    output logic [ADDR_WIDTH-1:0] tail_addr
);

    logic [DEPTH-1:0]                 vld_pipe;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] check_pipe;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_pipe;

    // Shifts every edge so the tail lines up with a fixed edge count.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld_pipe   <= '0;
            check_pipe <= '0;
            addr_pipe  <= '0;
        end else begin
            vld_pipe[0]   <= push_vld;
            check_pipe[0] <= push_check;
            addr_pipe[0]  <= push_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i]   <= vld_pipe[i-1];
                check_pipe[i] <= check_pipe[i-1];
                addr_pipe[i]  <= addr_pipe[i-1];
            end
        end
    end

    assign tail_vld   = vld_pipe[DEPTH-1];
    assign tail_check = check_pipe[DEPTH-1];
    assign tail_addr  = addr_pipe[DEPTH-1];

endmodule

// File: rtl/bist_checker.sv
// BIST checker: issues patgen ops to the SRAM and scores delayed read data.
// Optional BIST_CHECKER_FAILBITS_EN adds the OR-accumulated fail_bits output.
module bist_checker
    import bist_checker_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = 4,
    parameter int READ_LATENCY   = 1,
    parameter int FAIL_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      start,
    output logic                      pg_en,
    input  logic [ADDR_WIDTH-1:0]     pg_addr,
    input  logic                      pg_we,
    input  logic                      pg_re,
    input  logic [DATA_WIDTH-1:0]     pg_data,
    input  logic [DATA_WIDTH-1:0]     pg_check,
    input  logic [MASK_WIDTH-1:0]     pg_wmask,
    input  logic                      pg_done,
    output logic                      sram_ce,
    output logic                      sram_we,
    output logic [ADDR_WIDTH-1:0]     sram_addr,
    output logic [DATA_WIDTH-1:0]     sram_din,
    output logic [MASK_WIDTH-1:0]     sram_wmask,
    input  logic [DATA_WIDTH-1:0]     sram_dout,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]     first_fail_addr,
    output logic [DATA_WIDTH-1:0]     first_fail_data
`ifdef BIST_CHECKER_FAILBITS_EN
   ,output logic [DATA_WIDTH-1:0]     fail_bits
`endif
);

    localparam int PIPE_DEPTH = 1 + READ_LATENCY;
    localparam int DRAIN_CYC  = drain_len(READ_LATENCY);
    localparam int DCW        = $clog2(DRAIN_CYC + 1);

    bist_checker_state_t   state, state_nxt;
    logic [DCW-1:0]        drain_cnt;
    logic                  issue, run_entry, fail_flag, mismatch;
    logic                  tail_vld;
    logic [DATA_WIDTH-1:0] tail_check;
    logic [ADDR_WIDTH-1:0] tail_addr;

    // The op presented alongside pg_done is still issued, hence issue != pg_en.
    assign issue = (state == RUN);
    assign pg_en = issue && !pg_done;
    assign busy  = (state == RUN) || (state == DRAIN);
    assign done  = (state == DONE);
    assign pass  = done && (fail_count == '0);

    always_comb begin
        state_nxt = state;
        run_entry = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                state_nxt = RUN;
                run_entry = 1'b1;
            end
            RUN:   if (pg_done) state_nxt = DRAIN;
            DRAIN: if (drain_cnt == DCW'(DRAIN_CYC - 1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            sram_wmask <= '0;
        end else if (issue) begin
            sram_ce    <= pg_we | pg_re;
            sram_we    <= pg_we;
            sram_addr  <= pg_addr;
            sram_din   <= pg_data;
            sram_wmask <= pg_wmask;
        end else begin
            sram_ce <= 1'b0;
            sram_we <= 1'b0;
        end
    end

    bist_exp_pipe #(
        .DEPTH      (PIPE_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_exp_pipe (
        .clk        (clk),
        .rstb       (rstb),
        .push_vld   (issue && pg_re),
        .push_check (pg_check),
        .push_addr  (pg_addr),
        .tail_vld   (tail_vld),
        .tail_check (tail_check),
        .tail_addr  (tail_addr)
    );

    // Full-word compare; write mask has no meaning for reads.
    assign mismatch = tail_vld && (sram_dout != tail_check);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fail_count      <= '0;
            fail_flag       <= 1'b0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (run_entry) begin
            fail_count      <= '0;
            fail_flag       <= 1'b0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (mismatch) begin
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
            if (!fail_flag) begin
                fail_flag       <= 1'b1;
                first_fail_addr <= tail_addr;
                first_fail_data <= sram_dout;
            end
        end
    end

`ifdef BIST_CHECKER_FAILBITS_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)          fail_bits <= '0;
        else if (run_entry) fail_bits <= '0;
        else if (tail_vld)  fail_bits <= fail_bits | (sram_dout ^ tail_check);
    end
`endif

endmodule

// File: tb/tb_bist_checker.sv
// Self-checking bench: march C- patgen, SRAM model with fault injection, cycle model.
module tb_bist_checker;

    localparam int AW = 4, DW = 8, MW = 2, RL = 2, FW = 2, N = 160;

    logic          clk = 1'b0, rstb = 1'b0, start = 1'b0;
    logic          pg_en, pg_we, pg_re, pg_done;
    logic [AW-1:0] pg_addr, sram_addr, first_fail_addr;
    logic [DW-1:0] pg_data, pg_check, sram_din, sram_dout, first_fail_data;
    logic [MW-1:0] pg_wmask, sram_wmask;
    logic          sram_ce, sram_we, busy, done, pass;
    logic [FW-1:0] fail_count;
`ifdef BIST_CHECKER_FAILBITS_EN
    logic [DW-1:0] fail_bits;
`endif

    int errors = 0, checks = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    bist_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
        .READ_LATENCY(RL), .FAIL_CNT_WIDTH(FW)
    ) dut (
        .clk(clk), .rstb(rstb), .start(start), .pg_en(pg_en),
        .pg_addr(pg_addr), .pg_we(pg_we), .pg_re(pg_re), .pg_data(pg_data),
        .pg_check(pg_check), .pg_wmask(pg_wmask), .pg_done(pg_done),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_wmask(sram_wmask), .sram_dout(sram_dout),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_addr(first_fail_addr), .first_fail_data(first_fail_data)
`ifdef BIST_CHECKER_FAILBITS_EN
       ,.fail_bits(fail_bits)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- march C- pattern generator ----------------
    logic [AW-1:0] op_addr [N];
    logic          op_we   [N];
    logic [DW-1:0] op_val  [N];
    int            idx = 0, nops = 0;
    logic          pg_clr = 1'b1, dol = 1'b0;

    task automatic add_op(input logic w, input int a, input logic [DW-1:0] v);
        op_addr[nops] = AW'(a);
        op_we[nops]   = w;
        op_val[nops]  = v;
        nops++;
    endtask

    task automatic build_march();
        nops = 0;
        for (int a = 0; a < 16; a++) add_op(1'b1, a, 8'h00);
        for (int a = 0; a < 16; a++) begin add_op(1'b0, a, 8'h00); add_op(1'b1, a, 8'hFF); end
        for (int a = 0; a < 16; a++) begin add_op(1'b0, a, 8'hFF); add_op(1'b1, a, 8'h00); end
        for (int a = 15; a >= 0; a--) begin add_op(1'b0, a, 8'h00); add_op(1'b1, a, 8'hFF); end
        for (int a = 15; a >= 0; a--) begin add_op(1'b0, a, 8'hFF); add_op(1'b1, a, 8'h00); end
        for (int a = 0; a < 16; a++) add_op(1'b0, a, 8'h00);
    endtask

    always_comb begin
        pg_addr  = '0;
        pg_we    = 1'b0;
        pg_re    = 1'b0;
        pg_data  = '0;
        pg_check = '0;
        pg_wmask = '0;
        if (idx < N) begin
            pg_addr  = op_addr[idx];
            pg_we    = op_we[idx];
            pg_re    = !op_we[idx];
            pg_data  = op_we[idx] ? op_val[idx] : 8'h00;
            pg_check = op_we[idx] ? 8'h00 : op_val[idx];
            pg_wmask = '1;
        end
        // dol: pg_done raised while the final read is still presented
        pg_done = (idx >= N) || (dol && idx == N - 1);
    end

    always @(posedge clk) begin
        if (pg_clr) idx <= 0;
        else if (pg_en && idx < N) idx <= idx + 1;
    end

    // ---------------- SRAM with fault injection ----------------
    int            fault = 0;
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd1 = '0, rd2 = '0;

    function automatic logic [DW-1:0] flt(input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (fault)
            1:       return (a == 4'h5) ? (d | 8'h08) : d;
            2:       return d ^ 8'h01;
            3:       return (a == 4'hF) ? (d | 8'h08) : d;
            default: return d;
        endcase
    endfunction

    function automatic logic [DW-1:0] wmerge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                             input logic [MW-1:0] m);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = m[i / (DW / MW)] ? n[i] : o[i];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_ce && sram_we) mem[sram_addr] <= wmerge(mem[sram_addr], sram_din, sram_wmask);
        if (sram_ce && !sram_we) rd1 <= flt(sram_addr, mem[sram_addr]);
        rd2 <= rd1;
    end
    assign sram_dout = rd2;

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] got;
        logic [DW-1:0] expv;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] ref_mem [16];
    logic          m_run = 0, m_done = 0, m_ce = 0, m_we = 0, m_flag = 0;
    int            m_drain = 0, m_fcnt = 0, cyc = 0;
    logic [AW-1:0] m_addr = '0, m_ffa = '0;
    logic [DW-1:0] m_din = '0, m_ffd = '0;
    logic [MW-1:0] m_wmask = '0;

    initial forever begin
        @(posedge clk or negedge rstb);
        if (!rstb) begin
            m_run = 0; m_done = 0; m_ce = 0; m_we = 0; m_flag = 0; m_drain = 0; m_fcnt = 0;
            m_addr = '0; m_ffa = '0; m_din = '0; m_ffd = '0; m_wmask = '0;
            pend.delete();
        end else begin
            cyc++;
            // a read issued at edge k is scored at edge k+1+RL
            while (pend.size() > 0 && pend[0].due == cyc) begin
                rd_t r;
                r = pend.pop_front();
                if (r.got != r.expv) begin
                    if (m_fcnt < (1 << FW) - 1) m_fcnt++;
                    if (!m_flag) begin m_flag = 1; m_ffa = r.addr; m_ffd = r.got; end
                end
            end
            if (m_run) begin
                m_ce = pg_we | pg_re; m_we = pg_we; m_addr = pg_addr;
                m_din = pg_data; m_wmask = pg_wmask;
                if (pg_re) pend.push_back('{cyc + 1 + RL, pg_addr, flt(pg_addr, ref_mem[pg_addr]), pg_check});
                if (pg_we) ref_mem[pg_addr] = wmerge(ref_mem[pg_addr], pg_data, pg_wmask);
                if (pg_done) begin m_run = 0; m_drain = RL + 1; end
            end else begin
                m_ce = 0; m_we = 0;
                if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_done = 1;
                end else if (start) begin
                    m_run = 1; m_done = 0; m_fcnt = 0; m_flag = 0; m_ffa = '0; m_ffd = '0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rstb && chk_on) begin
            chk("pg_en",      pg_en,           m_run && !pg_done);
            chk("sram_ce",    sram_ce,         m_ce);
            chk("sram_we",    sram_we,         m_we);
            chk("sram_addr",  sram_addr,       m_addr);
            chk("sram_din",   sram_din,        m_din);
            chk("sram_wmask", sram_wmask,      m_wmask);
            chk("busy",       busy,            m_run || m_drain > 0);
            chk("done",       done,            m_done);
            chk("pass",       pass,            m_done && m_fcnt == 0);
            chk("fail_count", fail_count,      m_fcnt);
            chk("ff_addr",    first_fail_addr, m_ffa);
            chk("ff_data",    first_fail_data, m_ffd);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_pg_en"},   pg_en, 0);
        chk({tag, "_ce"},      sram_ce, 0);
        chk({tag, "_we"},      sram_we, 0);
        chk({tag, "_addr"},    sram_addr, 0);
        chk({tag, "_din"},     sram_din, 0);
        chk({tag, "_wmask"},   sram_wmask, 0);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_done"},    done, 0);
        chk({tag, "_pass"},    pass, 0);
        chk({tag, "_fcnt"},    fail_count, 0);
        chk({tag, "_ffa"},     first_fail_addr, 0);
        chk({tag, "_ffd"},     first_fail_data, 0);
    endtask

    // mid_start: pulse start while RUN; abort_at: async reset at that cycle
    task automatic run(input int f, input logic d, input logic mid_start, input int abort_at,
                       output int en_cnt);
        en_cnt = 0;
        @(negedge clk); fault = f; dol = d; pg_clr = 1'b1;
        @(negedge clk); pg_clr = 1'b0; start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            start = mid_start && (i == 20);
            if (abort_at != 0 && i == abort_at) begin
                #2 rstb = 1'b0;
                #1 chk_reset("abort");
                @(negedge clk); rstb = 1'b1;
                return;
            end
            if (pg_en) en_cnt++;
            if (done) break;
        end
        chk("done_reached", done, 1);
    endtask

    int en;

    initial begin
        build_march();
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rstb = 1'b1;
        chk_on = 1'b1;

        run(0, 1'b0, 1'b0, 0, en);
        chk("good_pass", pass, 1);
        chk("good_fcnt", fail_count, 0);
        chk("good_en_cycles", en, 160);

        run(1, 1'b0, 1'b0, 0, en);
        chk("sa1_pass", pass, 0);
        chk("sa1_fcnt", fail_count, 3);
        chk("sa1_ffa", first_fail_addr, 4'h5);
        chk("sa1_ffd", first_fail_data, 8'h08);
`ifdef BIST_CHECKER_FAILBITS_EN
        chk("sa1_fail_bits", fail_bits, 8'h08);
`endif

        run(2, 1'b0, 1'b1, 0, en);
        chk("sat_fcnt", fail_count, 3);
        chk("sat_ffa", first_fail_addr, 4'h0);
        chk("sat_ffd", first_fail_data, 8'h01);
        chk("sat_en_cycles", en, 160);

        run(3, 1'b1, 1'b0, 0, en);
        chk("last_rd_fcnt", fail_count, 3);
        chk("last_rd_ffa", first_fail_addr, 4'hF);
        chk("last_rd_ffd", first_fail_data, 8'h08);
        chk("last_rd_en_cycles", en, 159);

        run(0, 1'b0, 1'b0, 30, en);
        run(0, 1'b0, 1'b0, 0, en);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_fcnt", fail_count, 0);
        chk("post_rst_ffa", first_fail_addr, 0);
        chk("post_rst_ffd", first_fail_data, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
